// File: rtl/eeg_sample_feeder_pkg.sv
// rtl/eeg_sample_feeder_pkg.sv - shared types and project defaults for the EEG sample feeder
package eeg_sample_feeder_pkg;

  localparam int EEG_SAMPLE_DEPTH  = 16;
  localparam int EEG_EPOCH_SAMPLES = 3000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/eeg_sample_feeder_sample_fifo.sv
// rtl/eeg_sample_feeder_sample_fifo.sv - synchronous FIFO, registered pointers wrapped by power-of-two masking
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q + AW'(1)) & AW'(DEPTH-1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q + AW'(1)) & AW'(DEPTH-1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/eeg_sample_feeder.sv
// rtl/eeg_sample_feeder.sv - buffers ADC samples and releases spaced new_eeg_sample pulses with epoch tracking
// Optional input offset subtraction is built when EEG_FEEDER_OFFSET_EN is defined.
module eeg_sample_feeder
  import eeg_sample_feeder_pkg::*;
#(
  parameter int EEG_SAMPLE_DEPTH = eeg_sample_feeder_pkg::EEG_SAMPLE_DEPTH,
  parameter int FIFO_DEPTH       = 8,
  parameter int MIN_GAP          = 4,
  parameter int EPOCH_SAMPLES    = eeg_sample_feeder_pkg::EEG_EPOCH_SAMPLES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          adc_valid,
  input  logic [EEG_SAMPLE_DEPTH-1:0]   adc_sample,
`ifdef EEG_FEEDER_OFFSET_EN
  input  logic [EEG_SAMPLE_DEPTH-1:0]   adc_offset,
`endif
  output logic                          adc_ready,
  input  logic                          enable,
  input  logic                          clear_overflow,
  output logic                          new_eeg_sample,
  output logic [EEG_SAMPLE_DEPTH-1:0]   eeg_sample,
  output logic                          epoch_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

  localparam int GW = $clog2(MIN_GAP + 2);
  localparam int EW = $clog2(EPOCH_SAMPLES);

  feeder_state_t               state_q, state_d;
  logic [GW-1:0]               gap_q, gap_d;
  logic [EW-1:0]               epoch_cnt_q, epoch_cnt_d;
  logic                        new_q, new_d;
  logic                        epoch_done_q, epoch_done_d;
  logic                        overflow_q, overflow_d;
  logic [EEG_SAMPLE_DEPTH-1:0] sample_q, sample_d;

  logic                        fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
  logic [EEG_SAMPLE_DEPTH-1:0] fifo_wdata, fifo_rdata;

`ifdef EEG_FEEDER_OFFSET_EN
  logic [EEG_SAMPLE_DEPTH:0]   offset_diff;
  assign offset_diff = {1'b0, adc_sample} - {1'b0, adc_offset};
  assign fifo_wdata  = offset_diff[EEG_SAMPLE_DEPTH] ? '0 : offset_diff[EEG_SAMPLE_DEPTH-1:0];
`else
  assign fifo_wdata  = adc_sample;
`endif

  assign adc_ready = !fifo_full;
  assign fifo_push = adc_valid && !fifo_full;
  assign drop      = adc_valid && fifo_full;

  sample_fifo #(
    .WIDTH (EEG_SAMPLE_DEPTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fill_level)
  );

  // The pulse, sample and epoch flag are registered on the IDLE->EMIT edge so
  // they are visible during the EMIT cycle itself; the head is popped in EMIT.
  // The IDLE decision cycle counts as the last gap cycle, so a backlogged FIFO
  // emits exactly MIN_GAP cycles apart.
  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    epoch_cnt_d  = epoch_cnt_q;
    new_d        = 1'b0;
    epoch_done_d = 1'b0;
    sample_d     = sample_q;
    fifo_pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && !fifo_empty) begin
          state_d  = EMIT;
          new_d    = 1'b1;
          sample_d = fifo_rdata;
          if (epoch_cnt_q == EW'(EPOCH_SAMPLES - 1)) begin
            epoch_cnt_d  = '0;
            epoch_done_d = 1'b1;
          end else begin
            epoch_cnt_d  = epoch_cnt_q + EW'(1);
          end
        end
      end
      EMIT: begin
        fifo_pop = 1'b1;
        gap_d    = GW'(MIN_GAP - 1);
        state_d  = (MIN_GAP > 2) ? GAP : IDLE;
      end
      GAP: begin
        gap_d = gap_q - GW'(1);
        if (gap_q <= GW'(2)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      gap_q        <= '0;
      epoch_cnt_q  <= '0;
      new_q        <= 1'b0;
      epoch_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      sample_q     <= '0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      epoch_cnt_q  <= epoch_cnt_d;
      new_q        <= new_d;
      epoch_done_q <= epoch_done_d;
      overflow_q   <= overflow_d;
      sample_q     <= sample_d;
    end
  end

  assign new_eeg_sample = new_q;
  assign eeg_sample     = sample_q;
  assign epoch_done     = epoch_done_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_eeg_sample_feeder.sv
// tb/tb_eeg_sample_feeder.sv - self-checking bench: directed vector table, corner sequences, randomized queue model
module tb_eeg_sample_feeder;

  localparam int W       = 16;
  localparam int FD      = 8;
  localparam int MG      = 4;
  localparam int EP      = 4;
  localparam int GAP_EFF = (MG < 2) ? 2 : MG;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          adc_valid = 1'b0;
  logic [W-1:0]  adc_sample = '0;
  logic          enable = 1'b0;
  logic          clear_overflow = 1'b0;
  logic          adc_ready;
  logic          new_eeg_sample;
  logic [W-1:0]  eeg_sample;
  logic          epoch_done;
  logic          overflow;
  logic [$clog2(FD):0] fill_level;
`ifdef EEG_FEEDER_OFFSET_EN
  logic [W-1:0]  adc_offset = '0;
  logic [W-1:0]  off_v = '0;
`endif

  always #5 clk = ~clk;

  eeg_sample_feeder #(
    .EEG_SAMPLE_DEPTH (W),
    .FIFO_DEPTH       (FD),
    .MIN_GAP          (MG),
    .EPOCH_SAMPLES    (EP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .adc_valid      (adc_valid),
    .adc_sample     (adc_sample),
`ifdef EEG_FEEDER_OFFSET_EN
    .adc_offset     (adc_offset),
`endif
    .adc_ready      (adc_ready),
    .enable         (enable),
    .clear_overflow (clear_overflow),
    .new_eeg_sample (new_eeg_sample),
    .eeg_sample     (eeg_sample),
    .epoch_done     (epoch_done),
    .overflow       (overflow),
    .fill_level     (fill_level)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: queue of stored samples plus pulse timing rules.
  logic [W-1:0] mq[$];
  int           cyc = 0;
  int           last_pulse = 0;
  bit           have_last = 0;
  bit           e_pulse = 0, e_epoch = 0, e_ovf = 0;
  logic [W-1:0] e_data = '0;
  int           ep_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] stored(input logic [W-1:0] s);
`ifdef EEG_FEEDER_OFFSET_EN
    return (s > off_v) ? s - off_v : '0;
`else
    return s;
`endif
  endfunction

  task automatic tick();
    bit           ready_now, pulse_next;
    logic [W-1:0] head;
`ifdef EEG_FEEDER_OFFSET_EN
    adc_offset = off_v;
`endif
    if (rst) begin
      mq.delete();
      have_last = 0;
      e_pulse = 0; e_data = '0; e_epoch = 0; e_ovf = 0; ep_cnt = 0;
    end else begin
      ready_now  = mq.size() < FD;
      pulse_next = enable && (mq.size() > 0) && (!have_last || (cyc + 1 - last_pulse) >= GAP_EFF);
      head       = (mq.size() > 0) ? mq[0] : '0;
      if (e_pulse) void'(mq.pop_front());
      if (adc_valid && ready_now) mq.push_back(stored(adc_sample));
      if (adc_valid && !ready_now) e_ovf = 1;
      else if (clear_overflow) e_ovf = 0;
      e_epoch = 0;
      if (pulse_next) begin
        e_data = head;
        have_last = 1;
        last_pulse = cyc + 1;
        ep_cnt++;
        if (ep_cnt == EP) begin
          e_epoch = 1;
          ep_cnt = 0;
        end
      end
      e_pulse = pulse_next;
    end
    cyc++;
    @(posedge clk);
    #1;
    check("model_ready", adc_ready, (mq.size() < FD));
    check("model_pulse", new_eeg_sample, e_pulse);
    check("model_sample", eeg_sample, e_data);
    check("model_epoch", epoch_done, e_epoch);
    check("model_overflow", overflow, e_ovf);
    check("model_fill", fill_level, mq.size());
  endtask

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         p;
    logic [W-1:0] q;
    logic         e;
    int           f;
  } vec_t;

  vec_t vt[23];

  function automatic vec_t mk(logic v, logic [W-1:0] d, logic p, logic [W-1:0] q, logic e, int f);
    vec_t r;
    r.v = v; r.d = d; r.p = p; r.q = q; r.e = e; r.f = f;
    return r;
  endfunction

  initial begin
    int npulse, nepoch;
    logic [W-1:0] got[$];

    // Single sample at row 0, then five back-to-back pushes; pulses MG apart, epoch on 4th pulse.
    vt[0]  = mk(1, 16'h1234, 0, 16'h0000, 0, 1);
    vt[1]  = mk(0, 16'h0000, 1, 16'h1234, 0, 1);
    vt[2]  = mk(0, 16'h0000, 0, 16'h1234, 0, 0);
    vt[3]  = mk(0, 16'h0000, 0, 16'h1234, 0, 0);
    vt[4]  = mk(1, 16'hA001, 0, 16'h1234, 0, 1);
    vt[5]  = mk(1, 16'hA002, 1, 16'hA001, 0, 2);
    vt[6]  = mk(1, 16'hA003, 0, 16'hA001, 0, 2);
    vt[7]  = mk(1, 16'hA004, 0, 16'hA001, 0, 3);
    vt[8]  = mk(1, 16'hA005, 0, 16'hA001, 0, 4);
    vt[9]  = mk(0, 16'h0000, 1, 16'hA002, 0, 4);
    vt[10] = mk(0, 16'h0000, 0, 16'hA002, 0, 3);
    vt[11] = mk(0, 16'h0000, 0, 16'hA002, 0, 3);
    vt[12] = mk(0, 16'h0000, 0, 16'hA002, 0, 3);
    vt[13] = mk(0, 16'h0000, 1, 16'hA003, 1, 3);
    vt[14] = mk(0, 16'h0000, 0, 16'hA003, 0, 2);
    vt[15] = mk(0, 16'h0000, 0, 16'hA003, 0, 2);
    vt[16] = mk(0, 16'h0000, 0, 16'hA003, 0, 2);
    vt[17] = mk(0, 16'h0000, 1, 16'hA004, 0, 2);
    vt[18] = mk(0, 16'h0000, 0, 16'hA004, 0, 1);
    vt[19] = mk(0, 16'h0000, 0, 16'hA004, 0, 1);
    vt[20] = mk(0, 16'h0000, 0, 16'hA004, 0, 1);
    vt[21] = mk(0, 16'h0000, 1, 16'hA005, 0, 1);
    vt[22] = mk(0, 16'h0000, 0, 16'hA005, 0, 0);

    rst = 1;
    tick();
    check("reset_ready", adc_ready, 1);
    check("reset_pulse", new_eeg_sample, 0);
    check("reset_sample", eeg_sample, 0);
    check("reset_fill", fill_level, 0);
    tick();
    rst = 0;
    enable = 1;
    for (int i = 0; i < 23; i++) begin
      adc_valid = vt[i].v;
      adc_sample = vt[i].d;
      tick();
      check($sformatf("vec%0d_pulse", i), new_eeg_sample, vt[i].p);
      check($sformatf("vec%0d_sample", i), eeg_sample, vt[i].q);
      check($sformatf("vec%0d_epoch", i), epoch_done, vt[i].e);
      check($sformatf("vec%0d_fill", i), fill_level, vt[i].f);
    end

    // Overflow with emission held off, then drain with epoch marks on pulses 4 and 8.
    rst = 1; tick(); tick(); rst = 0;
    enable = 0;
    for (int k = 0; k < 9; k++) begin
      adc_valid = 1;
      adc_sample = W'(16'h0100 + k);
      tick();
      if (k == 7) check("ready_low_when_full", adc_ready, 0);
    end
    adc_valid = 0;
    check("overflow_after_drop", overflow, 1);
    check("fill_full", fill_level, FD);
    clear_overflow = 1; tick(); clear_overflow = 0;
    check("overflow_cleared", overflow, 0);
    enable = 1;
    npulse = 0; nepoch = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (new_eeg_sample) begin
        npulse++;
        check("drain_value", eeg_sample, W'(16'h0100 + npulse - 1));
        check("drain_epoch", epoch_done, (npulse % EP) == 0);
      end
      if (epoch_done) nepoch++;
    end
    check("drain_pulse_count", npulse, 8);
    check("drain_epoch_count", nepoch, 2);

    // Reset with samples buffered: nothing may emerge afterwards.
    enable = 0;
    for (int k = 0; k < 3; k++) begin
      adc_valid = 1; adc_sample = W'(16'h0200 + k); tick();
    end
    adc_valid = 0;
    rst = 1; tick(); tick();
    check("midrst_pulse", new_eeg_sample, 0);
    check("midrst_sample", eeg_sample, 0);
    check("midrst_fill", fill_level, 0);
    check("midrst_ready", adc_ready, 1);
    rst = 0; enable = 1;
    npulse = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (new_eeg_sample) npulse++;
    end
    check("midrst_no_pulse", npulse, 0);

`ifdef EEG_FEEDER_OFFSET_EN
    off_v = 16'd100;
    adc_valid = 1; adc_sample = 16'd150; tick();
    adc_sample = 16'd50; tick();
    adc_valid = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (new_eeg_sample) got.push_back(eeg_sample);
    end
    check("offset_count", got.size(), 2);
    if (got.size() == 2) begin
      check("offset_first", got[0], 16'd50);
      check("offset_second", got[1], 16'd0);
    end
`endif

    // Randomized traffic against the queue model.
    begin
      int dens;
      dens = 50;
      for (int i = 0; i < 3000; i++) begin
        if (i % 500 == 0) dens = $urandom_range(10, 90);
        adc_valid = ($urandom_range(0, 99) < dens);
        adc_sample = W'($urandom);
        if ($urandom_range(0, 39) == 0) enable = ~enable;
        clear_overflow = ($urandom_range(0, 29) == 0);
        rst = ($urandom_range(0, 599) == 0);
`ifdef EEG_FEEDER_OFFSET_EN
        if ($urandom_range(0, 99) == 0) off_v = W'($urandom_range(0, 65535));
`endif
        tick();
      end
      rst = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eeg_sample_feeder.md
Name: eeg_sample_feeder

Overview:
Upstream ingestion stage for the accelerator top. It accepts raw EEG samples from the ADC over a valid/ready handshake and buffers them in a small FIFO. Buffered samples are released to the master as single-cycle new_eeg_sample pulses with a guaranteed minimum spacing. It also counts delivered samples and flags each completed sleep epoch to the RISC-V.

Parameters:
EEG_SAMPLE_DEPTH, 16, width of one unsigned EEG sample.
FIFO_DEPTH, 8, buffer entries; power of two, >= 2.
MIN_GAP, 4, minimum clk cycles between consecutive new_eeg_sample pulses; >= 1.
EPOCH_SAMPLES, 3000, samples per sleep epoch; >= 2.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
adc_valid  in  1  ADC presents a sample
adc_sample  in  EEG_SAMPLE_DEPTH  ADC sample, unsigned
adc_ready  out  1  feeder can accept a sample
enable  in  1  RISC-V permits emission toward the master
clear_overflow  in  1  clears sticky overflow flag
new_eeg_sample  out  1  one-cycle pulse, eeg_sample valid
eeg_sample  out  EEG_SAMPLE_DEPTH  sample to master; held between pulses
epoch_done  out  1  one-cycle pulse on the last sample of an epoch
overflow  out  1  sticky; a sample was dropped
fill_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release): FIFO empty; adc_ready=1; new_eeg_sample=0; eeg_sample=0; epoch_done=0; overflow=0; fill_level=0; epoch counter=0; FSM=IDLE; gap counter=0.
- Push: adc_valid && adc_ready writes adc_sample. adc_ready = !full, decoded from registered occupancy only. A pop in the same cycle does not raise adc_ready.
- Drop: adc_valid && full discards the sample and sets overflow the next cycle. The ADC cannot stall, so this is a real drop.
- overflow clears on clear_overflow. If clear_overflow and a new drop occur in the same cycle, set wins.
- FSM states: IDLE, EMIT, GAP.
- IDLE -> EMIT when enable && !empty.
- EMIT lasts exactly one cycle. It pops the head, registers it onto eeg_sample, asserts new_eeg_sample for that cycle, and loads the gap counter with MIN_GAP-1. Next state is GAP if MIN_GAP>1; otherwise IDLE.
- GAP: decrement the counter each cycle. At 0, go to IDLE.
- Resulting spacing between pulses is at least MIN_GAP cycles; an IDLE cycle may add more.
- Latency: a sample pushed at cycle t into an empty FIFO with FSM in IDLE and enable=1 produces its pulse at cycle t+2 (FIFO write at t, IDLE decision at t+1, EMIT output registered at t+2).
- enable low: no new EMIT. An in-progress GAP still completes. FIFO keeps filling and the epoch counter is preserved.
- Epoch counter increments on every pulse. On the pulse that brings it to EPOCH_SAMPLES, epoch_done is asserted in the same cycle as new_eeg_sample and the counter wraps to 0.
- fill_level updates every cycle. Simultaneous push and pop leaves the level unchanged.
- Dropped samples do not count toward the epoch.
- Reset mid-operation discards all buffered samples and the epoch count. No pulse occurs during reset.

Optional Feature:
EEG_FEEDER_OFFSET_EN
- Defined: adds input port adc_offset (EEG_SAMPLE_DEPTH bits, unsigned). The stored sample is sat(adc_sample - adc_offset), computed at push with one extra sign bit and clamped at 0. adc_offset is sampled at the push cycle.
- Undefined: port absent; samples pass through unchanged.

Decomposition:
- EEG_SAMPLE_DEPTH stays in the shared types.svh package.
- Add to the package: typedef enum feeder_state_t {IDLE, EMIT, GAP}, and EEG_EPOCH_SAMPLES as the project default.
- One sub-module: sample_fifo, a synchronous FIFO with params WIDTH and DEPTH. Ports: push, pop, wdata, rdata, full, empty, count. Registered pointers; wrap by power-of-two masking.

Test Plan:
- Single sample: enable=1, push 0x1234 at cycle 10 -> new_eeg_sample=1 at cycle 12, eeg_sample=0x1234, held afterwards; fill_level returns to 0.
- Back-to-back pushes: push 5 samples on consecutive cycles, MIN_GAP=4 -> 5 pulses 4 cycles apart, in order, values match.
- Overflow: enable=0, push 9 samples with FIFO_DEPTH=8 -> adc_ready=0 after the 8th push, 9th sample dropped, overflow=1. clear_overflow -> 0. Then enable=1 -> exactly 8 pulses.
- Epoch: EPOCH_SAMPLES=4, feed 9 samples -> epoch_done coincides with pulses 4 and 8 only.
- Reset mid-operation: 3 samples buffered, assert rst for 2 cycles -> all outputs 0, fill_level=0, no further pulses.
- Offset (macro defined): adc_offset=100, push 150 and 50 -> emitted 50 and 0.
